// File: rtl/retro_bus_pkg.sv
// Shared types for the core-to-memory stall bridge: FSM states, the captured
// bus request and the saturating stall-counter helper.
package retro_bus_pkg;

  // Widest address/data a bridge instance may use; requests are stored
  // zero-extended to these widths and narrowed again on issue.
  localparam int unsigned BusAddrMax = 64;
  localparam int unsigned BusDataMax = 64;

  localparam logic [15:0] StallMax = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } mem_stall_state_t;

  typedef struct packed {
    logic                  write;
    logic [BusAddrMax-1:0] addr;
    logic [BusDataMax-1:0] wdata;
  } bus_req_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == StallMax) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/retro_stall_timer.sv
// Per-access stall timer: loads zero on Clear, counts while Enable and holds
// at the last count, where Expire stays asserted.
module retro_stall_timer #(
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic Clear,
  input  logic Enable,
  output logic Expire
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] count;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable && !Expire) begin
      count <= count + CntWidth'(1);
    end
  end

  assign Expire = (count == LastCount);

endmodule

// File: rtl/retro_mem_stall.sv
// Memory stall bridge: captures one core access per tick, forwards it over a
// valid/ready handshake and holds Delay high until the access completes.
module retro_mem_stall
  import retro_bus_pkg::*;
#(
  parameter int unsigned          AddrWidth     = 24,
  parameter int unsigned          DataWidth     = 8,
  parameter int unsigned          TimeoutCycles = 4096,
  parameter logic [DataWidth-1:0] OpenBus       = '1
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 ClkEn,
  input  logic                 CoreCE,
  input  logic                 CoreReq,
  input  logic                 CoreWrite,
  input  logic [AddrWidth-1:0] CoreAddr,
  input  logic [DataWidth-1:0] CoreWData,
  output logic [DataWidth-1:0] CoreRData,
  output logic                 CoreRValid,
  output logic                 Delay,
  output logic                 MemValid,
  input  logic                 MemReady,
  output logic                 MemWrite,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] MemWData,
  input  logic                 MemRValid,
  input  logic [DataWidth-1:0] MemRData,
  output logic                 Timeout,
  input  logic                 StatClear,
  output logic [15:0]          StallCycles
);

  mem_stall_state_t state;
  bus_req_t         pendReq;
  bus_req_t         coreReqNow;
  bus_req_t         drainReq;
  logic             pending;
  logic             capture;
  logic             timerRun;
  logic             timerClear;
  logic             timerExpire;
  logic             timeoutHit;

  assign capture    = ClkEn && CoreCE && CoreReq;
  assign timerRun   = (state == ISSUE) || (state == WAIT);
  assign timerClear = !timerRun;

  assign coreReqNow = {CoreWrite, BusAddrMax'(CoreAddr), BusDataMax'(CoreWData)};
  // A capture arriving in the same cycle as the discarded response issues directly.
  assign drainReq   = pending ? pendReq : coreReqNow;

  // Completion in the expiry cycle wins over the timeout.
  assign timeoutHit = timerExpire &&
                      (((state == ISSUE) && !MemReady) ||
                       ((state == WAIT) && !MemRValid));

  retro_stall_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) uStallTimer (
    .Clk   (Clk),
    .ResetN(ResetN),
    .Clear (timerClear),
    .Enable(timerRun),
    .Expire(timerExpire)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      pending    <= 1'b0;
      pendReq    <= '0;
      MemValid   <= 1'b0;
      MemWrite   <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      Delay      <= 1'b0;
      CoreRData  <= '0;
      CoreRValid <= 1'b0;
    end else begin
      CoreRValid <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state    <= ISSUE;
            MemValid <= 1'b1;
            MemWrite <= CoreWrite;
            MemAddr  <= CoreAddr;
            MemWData <= CoreWData;
            Delay    <= 1'b1;
          end
        end

        ISSUE: begin
          if (MemReady) begin
            MemValid <= 1'b0;
            if (MemWrite) begin
              state <= IDLE;
              Delay <= 1'b0;
            end else if (MemRValid) begin
              CoreRData  <= MemRData;
              CoreRValid <= 1'b1;
              state      <= IDLE;
              Delay      <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end else if (timeoutHit) begin
            MemValid   <= 1'b0;
            CoreRData  <= OpenBus;
            CoreRValid <= 1'b1;
            state      <= IDLE;
            Delay      <= 1'b0;
          end
        end

        WAIT: begin
          if (MemRValid) begin
            CoreRData  <= MemRData;
            CoreRValid <= 1'b1;
            state      <= IDLE;
            Delay      <= 1'b0;
          end else if (timeoutHit) begin
            CoreRData  <= OpenBus;
            CoreRValid <= 1'b1;
            state      <= DRAIN;
            Delay      <= 1'b0;
          end
        end

        DRAIN: begin
          if (MemRValid) begin
            if (pending || capture) begin
              state    <= ISSUE;
              pending  <= 1'b0;
              MemValid <= 1'b1;
              MemWrite <= drainReq.write;
              MemAddr  <= AddrWidth'(drainReq.addr);
              MemWData <= DataWidth'(drainReq.wdata);
              Delay    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (capture && !pending) begin
            pending <= 1'b1;
            pendReq <= coreReqNow;
            Delay   <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Timeout <= 1'b0;
    end else begin
      if (StatClear) begin
        Timeout <= 1'b0;
      end
      if (timeoutHit) begin
        Timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      StallCycles <= '0;
    end else if (StatClear) begin
      StallCycles <= '0;
    end else if (Delay) begin
      StallCycles <= satInc16(StallCycles);
    end
  end

endmodule

// File: tb/tb_retro_mem_stall.sv
// Bench for retro_mem_stall: access-level reference model compared every
// cycle, directed scenarios with literal expectations, and random traffic.
`timescale 1ns/1ps
module tb_retro_mem_stall;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          Clk = 1'b0;
  logic          ResetN = 1'b0;
  logic          ClkEn = 1'b1;
  logic          CoreCE = 1'b0;
  logic          CoreReq = 1'b0;
  logic          CoreWrite = 1'b0;
  logic [AW-1:0] CoreAddr = '0;
  logic [DW-1:0] CoreWData = '0;
  logic [DW-1:0] CoreRData;
  logic          CoreRValid;
  logic          Delay;
  logic          MemValid;
  logic          MemReady = 1'b0;
  logic          MemWrite;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic          MemRValid = 1'b0;
  logic [DW-1:0] MemRData = '0;
  logic          Timeout;
  logic          StatClear = 1'b0;
  logic [15:0]   StallCycles;

  int checks = 0;
  int failures = 0;
  int cmpPrinted = 0;

  always #5 Clk = ~Clk;

  retro_mem_stall #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO),
    .OpenBus      ({DW{1'b1}})
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .ClkEn      (ClkEn),
    .CoreCE     (CoreCE),
    .CoreReq    (CoreReq),
    .CoreWrite  (CoreWrite),
    .CoreAddr   (CoreAddr),
    .CoreWData  (CoreWData),
    .CoreRData  (CoreRData),
    .CoreRValid (CoreRValid),
    .Delay      (Delay),
    .MemValid   (MemValid),
    .MemReady   (MemReady),
    .MemWrite   (MemWrite),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRValid  (MemRValid),
    .MemRData   (MemRData),
    .Timeout    (Timeout),
    .StatClear  (StatClear),
    .StallCycles(StallCycles)
  );

  // Access-level model: an outstanding access (busy), whether memory has
  // accepted it, a response still owed after a read timeout, and a capture
  // parked while that response is owed.
  bit            mBusy = 0;
  bit            mAccepted = 0;
  bit            mOwe = 0;
  bit            mPend = 0;
  bit            mRValid = 0;
  bit            mTimeout = 0;
  int unsigned   mAge = 0;
  int unsigned   mStall = 0;
  logic          mWrite = 1'b0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mWData = '0;
  logic [DW-1:0] mRData = '0;
  logic          pWrite = 1'b0;
  logic [AW-1:0] pAddr = '0;
  logic [DW-1:0] pWData = '0;

  task automatic modelReset();
    mBusy = 0; mAccepted = 0; mOwe = 0; mPend = 0; mRValid = 0; mTimeout = 0;
    mAge = 0; mStall = 0; mRData = '0;
  endtask

  task automatic startAccess(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mBusy = 1; mAccepted = 0; mAge = 0;
    mWrite = wr; mAddr = a; mWData = d;
  endtask

  task automatic modelStep();
    bit cap;
    bit stalledNow;
    bit finish;
    cap = ClkEn && CoreCE && CoreReq;
    stalledNow = mBusy || mPend;
    mRValid = 0;
    if (StatClear) mStall = 0;
    else if (stalledNow && mStall < 65535) mStall = mStall + 1;
    if (StatClear) mTimeout = 0;
    if (mBusy) begin
      finish = 0;
      if (!mAccepted && MemReady) begin
        if (mWrite) finish = 1;
        else if (MemRValid) begin mRData = MemRData; mRValid = 1; finish = 1; end
        else mAccepted = 1;
      end else if (mAccepted && MemRValid) begin
        mRData = MemRData; mRValid = 1; finish = 1;
      end else if (mAge >= TO - 1) begin
        mRData = '1; mRValid = 1; mTimeout = 1; finish = 1;
        mOwe = mAccepted;
      end
      if (finish) mBusy = 0;
      else if (mAge < TO - 1) mAge = mAge + 1;
    end else if (mOwe) begin
      if (cap && !mPend) begin
        mPend = 1; pWrite = CoreWrite; pAddr = CoreAddr; pWData = CoreWData;
      end
      if (MemRValid) begin
        mOwe = 0;
        if (mPend) begin
          mPend = 0;
          startAccess(pWrite, pAddr, pWData);
        end
      end
    end else if (cap) begin
      startAccess(CoreWrite, CoreAddr, CoreWData);
    end
  endtask

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) modelReset();
    else modelStep();
  end

  always @(negedge Clk) begin : compare
    bit ok;
    bit eMemValid;
    bit eDelay;
    eMemValid = mBusy && !mAccepted;
    eDelay = mBusy || mPend;
    ok = (Delay === eDelay) && (MemValid === eMemValid) && (CoreRValid === mRValid) &&
         (CoreRData === mRData) && (Timeout === mTimeout) && (StallCycles === 16'(mStall));
    if (!ResetN)
      ok = ok && (MemWrite === 1'b0) && (MemAddr === '0) && (MemWData === '0);
    else if (eMemValid)
      ok = ok && (MemWrite === mWrite) && (MemAddr === mAddr) && (MemWData === mWData);
    checks++;
    if (!ok) begin
      failures++;
      if (cmpPrinted < 30) begin
        cmpPrinted++;
        $display("FAIL cycle_compare t=%0t actual: Delay=%b MemValid=%b W=%b A=%h D=%h RValid=%b RData=%h Timeout=%b Stall=%0d required: Delay=%b MemValid=%b W=%b A=%h D=%h RValid=%b RData=%h Timeout=%b Stall=%0d",
                 $time, Delay, MemValid, MemWrite, MemAddr, MemWData, CoreRValid, CoreRData, Timeout, StallCycles,
                 eDelay, eMemValid, mWrite, mAddr, mWData, mRValid, mRData, mTimeout, mStall);
      end
    end
  end

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    CoreCE = 0; CoreReq = 0; CoreWrite = 0; MemReady = 0; MemRValid = 0; StatClear = 0;
  endtask

  task automatic coreAccess(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    assert (!mBusy && !mPend) else $error("protocol violation: core request while an access is outstanding");
    CoreCE = 1; CoreReq = 1; CoreWrite = wr; CoreAddr = a; CoreWData = d;
  endtask

  task automatic checkAllZero(input string tag);
    expectEq({tag, "_rdata"}, 32'(CoreRData), 0);
    expectEq({tag, "_ctrl"}, {26'd0, CoreRValid, Delay, MemValid, MemWrite, Timeout, 1'b0}, 0);
    expectEq({tag, "_maddr"}, 32'(MemAddr), 0);
    expectEq({tag, "_mwdata"}, 32'(MemWData), 0);
    expectEq({tag, "_stall"}, 32'(StallCycles), 0);
  endtask

  initial begin : main
    bit slow;
    repeat (3) @(posedge Clk);
    #1;
    checkAllZero("reset");
    ResetN = 1;
    tick();

    // Read against slow memory
    coreAccess(0, 24'h001234, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0; MemReady = 1;
    expectEq("rd_issue", {29'd0, MemValid, Delay, MemWrite}, 32'b110);
    expectEq("rd_addr", 32'(MemAddr), 32'h001234);
    tick();
    MemReady = 0;
    tick();
    tick();
    MemRValid = 1; MemRData = 8'h5A;
    expectEq("rd_delay_n4", 32'(Delay), 1);
    tick();
    MemRValid = 0;
    expectEq("rd_data", 32'(CoreRData), 32'h5A);
    expectEq("rd_done", {30'd0, CoreRValid, Delay}, 32'b10);
    expectEq("rd_stall", 32'(StallCycles), 4);
    expectEq("model_stall", mStall, 4);
    tick();

    // Write with backpressure
    coreAccess(1, 24'h00FFFE, 8'hA5);
    tick();
    CoreCE = 0; CoreReq = 0;
    for (int i = 0; i < 3; i++) begin
      expectEq("wr_hold_ctrl", {29'd0, MemValid, MemWrite, Delay}, 32'b111);
      expectEq("wr_hold_addr", 32'(MemAddr), 32'h00FFFE);
      expectEq("wr_hold_data", 32'(MemWData), 32'hA5);
      tick();
    end
    MemReady = 1;
    tick();
    MemReady = 0;
    expectEq("wr_done", {30'd0, MemValid, Delay}, 0);
    tick();

    // Read timeout, then capture during drain
    coreAccess(0, 24'h000020, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0; MemReady = 1;
    tick();
    MemReady = 0;
    repeat (15) tick();
    expectEq("to_rdata", 32'(CoreRData), 32'hFF);
    expectEq("to_flags", {29'd0, CoreRValid, Timeout, Delay}, 32'b110);
    expectEq("model_timeout_rdata", 32'(mRData), 32'hFF);
    coreAccess(0, 24'h000010, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0;
    expectEq("drain_pend_a", {30'd0, Delay, MemValid}, 32'b10);
    tick();
    expectEq("drain_pend_b", {30'd0, Delay, MemValid}, 32'b10);
    MemRValid = 1; MemRData = 8'h11;
    tick();
    MemRValid = 0;
    expectEq("drain_discard", 32'(CoreRData), 32'hFF);
    expectEq("drain_issue", {29'd0, MemValid, Delay, CoreRValid}, 32'b110);
    expectEq("drain_addr", 32'(MemAddr), 32'h000010);
    MemReady = 1; MemRValid = 1; MemRData = 8'h3C;
    tick();
    MemReady = 0; MemRValid = 0;
    expectEq("drain_read", 32'(CoreRData), 32'h3C);
    expectEq("drain_read_flags", {30'd0, CoreRValid, Delay}, 32'b10);
    StatClear = 1;
    tick();
    StatClear = 0;
    expectEq("clear_timeout", 32'(Timeout), 0);
    expectEq("clear_stall", 32'(StallCycles), 0);

    // Zero latency
    coreAccess(0, 24'h000777, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0;
    expectEq("zl_issue", {30'd0, Delay, MemValid}, 32'b11);
    MemReady = 1; MemRValid = 1; MemRData = 8'h77;
    tick();
    MemReady = 0; MemRValid = 0;
    expectEq("zl_done", {30'd0, CoreRValid, Delay}, 32'b10);
    expectEq("zl_data", 32'(CoreRData), 32'h77);
    expectEq("zl_stall", 32'(StallCycles), 1);
    tick();

    // ClkEn gating
    ClkEn = 0; CoreCE = 1; CoreReq = 1; CoreAddr = 24'h000400;
    tick();
    ClkEn = 1; CoreCE = 0; CoreReq = 0;
    expectEq("clken_gate", {30'd0, MemValid, Delay}, 0);
    tick();

    // Random traffic
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 400) == 0) slow = ~slow;
      ClkEn = ($urandom_range(0, 7) != 0);
      CoreCE = ($urandom_range(0, 2) == 0);
      CoreReq = CoreCE && !mBusy && !mPend && ($urandom_range(0, 1) == 1);
      CoreWrite = 1'($urandom_range(0, 1));
      CoreAddr = AW'($urandom);
      CoreWData = DW'($urandom);
      StatClear = ($urandom_range(0, 99) == 0);
      if (slow) MemReady = ($urandom_range(0, 11) == 0);
      else MemReady = ($urandom_range(0, 3) != 0);
      if ((mBusy && !mWrite) || mOwe)
        MemRValid = slow ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      else
        MemRValid = 0;
      MemRData = DW'($urandom);
      tick();
    end
    idleInputs();
    ClkEn = 1;
    repeat (40) begin
      if (mOwe) MemRValid = 1;
      else MemRValid = 0;
      MemReady = 1;
      tick();
    end
    idleInputs();
    tick();

    // Asynchronous reset while waiting on a read
    coreAccess(0, 24'h000ABC, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0; MemReady = 1;
    tick();
    MemReady = 0;
    tick();
    expectEq("wait_delay", 32'(Delay), 1);
    #2;
    ResetN = 0;
    #1;
    checkAllZero("async_reset");
    tick();
    ResetN = 1;
    tick();
    expectEq("post_reset_idle", {30'd0, MemValid, Delay}, 0);

    // Stall counter saturation
    coreAccess(0, 24'h000100, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0; MemReady = 1;
    tick();
    MemReady = 0;
    repeat (15) tick();
    coreAccess(0, 24'h000104, 8'h00);
    tick();
    CoreCE = 0; CoreReq = 0;
    repeat (65600) tick();
    expectEq("sat_value", 32'(StallCycles), 32'hFFFF);
    expectEq("sat_delay", {30'd0, Delay, MemValid}, 32'b10);
    tick();
    expectEq("sat_hold", 32'(StallCycles), 32'hFFFF);
    StatClear = 1;
    tick();
    StatClear = 0;
    expectEq("sat_clear_wins", 32'(StallCycles), 0);
    tick();
    expectEq("sat_restart", 32'(StallCycles), 1);
    MemRValid = 1;
    tick();
    MemRValid = 1; MemReady = 1; MemRData = 8'h42;
    tick();
    idleInputs();
    expectEq("sat_final_read", 32'(CoreRData), 32'h42);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
